// File: rtl/lab_pkg.sv
// Shared definitions for the lab ROM sequencers: FSM state encoding and ROM geometry.
package lab_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  localparam int unsigned ROM_ADDR_W = 3;
  localparam int unsigned ROM_DATA_W = 4;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StFetch   = ST_FETCH,
    StPresent = ST_PRESENT,
    StFinish  = ST_FINISH
  } state_e;

endpackage

// File: rtl/rom_reader_if.sv
// ROM address/data bus plus the downstream valid/ready word stream of rom_reader.
interface rom_reader_if
  import lab_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/rom_addr_counter.sv
// Loadable up-counter bounded to [Start, End]; incrementing at End wraps to Start explicitly.
module rom_addr_counter #(
  parameter int unsigned     Width = 3,
  parameter logic [Width-1:0] Start = '0,
  parameter logic [Width-1:0] End   = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             incr_i,
  output logic [Width-1:0] count_o,
  output logic             at_end_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign at_end_o = (cnt_q == End);
  assign count_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Start;
    end else if (incr_i) begin
      // Wrap by compare, not overflow, so a non-zero Start still works at the top of the space.
      cnt_d = at_end_o ? Start : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= Start;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Walks the lab ROM from START_ADDR to END_ADDR and streams each registered word downstream,
// with one-shot or looping playback and abort.
module rom_reader
  import lab_pkg::*;
#(
  parameter int unsigned ADDR_W     = ROM_ADDR_W,
  parameter int unsigned DATA_W     = ROM_DATA_W,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            loop,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  rom_reader_if.master    bus
);

  if (END_ADDR < START_ADDR) begin : g_bad_range
    $error("rom_reader: END_ADDR must be >= START_ADDR");
  end
  if (END_ADDR >= (1 << ADDR_W)) begin : g_bad_end
    $error("rom_reader: END_ADDR does not fit in ADDR_W bits");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              cnt_load, cnt_incr, at_end;

  rom_addr_counter #(
    .Width (ADDR_W),
    .Start (ADDR_W'(START_ADDR)),
    .End   (ADDR_W'(END_ADDR))
  ) u_addr_counter (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (cnt_load),
    .incr_i   (cnt_incr),
    .count_o  (bus.rom_addr),
    .at_end_o (at_end)
  );

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_incr    = 1'b0;
    if (abort) begin
      // Any pending word is dropped and no done pulse is produced.
      state_d     = StIdle;
      out_valid_d = 1'b0;
      cnt_load    = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_load = 1'b1;
          if (start) state_d = StFetch;
        end
        StFetch: begin
          out_data_d  = bus.rom_data;
          out_valid_d = 1'b1;
          state_d     = StPresent;
        end
        StPresent: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            if (!at_end || loop) begin
              cnt_incr = 1'b1;
              state_d  = StFetch;
            end else begin
              done_d  = 1'b1;
              state_d = StFinish;
            end
          end
        end
        StFinish: begin
          cnt_load = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader: full range (0..7) and looping sub-range (6..7) instances
// fed by a ROM model returning addr ^ 4'hA, checked against a queue of expected words.
module tb_rom_reader;

  logic clk, rst;
  logic start0, loop0, abort0, busy0, done0;
  logic start1, loop1, abort1, busy1, done1;

  rom_reader_if #(.ADDR_W(3), .DATA_W(4)) if0 ();
  rom_reader_if #(.ADDR_W(3), .DATA_W(4)) if1 ();

  assign if0.rom_data = {1'b0, if0.rom_addr} ^ 4'hA;
  assign if1.rom_data = {1'b0, if1.rom_addr} ^ 4'hA;

  rom_reader #(.ADDR_W(3), .DATA_W(4), .START_ADDR(0), .END_ADDR(7)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .start (start0),
    .loop  (loop0),
    .abort (abort0),
    .busy  (busy0),
    .done  (done0),
    .bus   (if0.master)
  );

  rom_reader #(.ADDR_W(3), .DATA_W(4), .START_ADDR(6), .END_ADDR(7)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .loop  (loop1),
    .abort (abort1),
    .busy  (busy1),
    .done  (done1),
    .bus   (if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_pass(input int first, input int last);
    for (int a = first; a <= last; a++) exp_q.push_back(4'(a) ^ 4'hA);
  endtask

  // Waits (bounded) for out_valid at a falling edge, then compares against the scoreboard.
  task automatic get_word(input int sel, input string tag, output int waited);
    logic       v;
    logic [3:0] obs, exp;
    v = 1'b0;
    waited = 0;
    while (!v && waited < 20) begin
      @(negedge clk);
      waited++;
      v = (sel != 0) ? if1.out_valid : if0.out_valid;
    end
    check({tag, "_valid"}, 32'(v), 32'd1);
    if (v) begin
      obs = (sel != 0) ? if1.out_data : if0.out_data;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      check({tag, "_data"}, 32'(obs), 32'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    {start0, loop0, abort0, start1, loop1, abort1} = '0;
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    #12;
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_valid", 32'(if0.out_valid), 0);
    check("rst_addr0", 32'(if0.rom_addr), 0);
    check("rst_data", 32'(if0.out_data), 0);
    check("rst_addr1", 32'(if1.rom_addr), 6);
    @(negedge clk);
    rst = 1'b0;

    // One-shot full pass at full throughput.
    push_pass(0, 7);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("t1_fetch_valid", 32'(if0.out_valid), 0);
    check("t1_fetch_busy", 32'(busy0), 1);
    for (int i = 0; i < 8; i++) begin
      get_word(0, "t1_word", w);
      check("t1_spacing", 32'(w), (i == 0) ? 1 : 2);
      check("t1_no_done", 32'(done0), 0);
    end
    @(negedge clk);
    check("t1_done", 32'(done0), 1);
    check("t1_fin_valid", 32'(if0.out_valid), 0);
    @(negedge clk);
    check("t1_done_drop", 32'(done0), 0);
    check("t1_idle_busy", 32'(busy0), 0);

    // Backpressure while word 8 (addr 2) is presented.
    push_pass(0, 7);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    get_word(0, "t2_a", w);
    get_word(0, "t2_b", w);
    get_word(0, "t2_8", w);
    if0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(if0.out_valid), 1);
      check("t2_hold_data", 32'(if0.out_data), 32'h8);
      check("t2_hold_addr", 32'(if0.rom_addr), 2);
    end
    if0.out_ready = 1'b1;
    get_word(0, "t2_9", w);
    check("t2_resume_gap", 32'(w), 2);
    for (int i = 0; i < 4; i++) get_word(0, "t2_tail", w);
    @(negedge clk);
    check("t2_done", 32'(done0), 1);
    @(negedge clk);

    // Looping sub-range 6..7 wrapping at the top of the address space.
    loop1 = 1'b1;
    push_pass(6, 7);
    push_pass(6, 7);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    get_word(1, "t3_c0", w);
    check("t3_addr6", 32'(if1.rom_addr), 6);
    get_word(1, "t3_d0", w);
    check("t3_addr7", 32'(if1.rom_addr), 7);
    get_word(1, "t3_c1", w);
    check("t3_no_done", 32'(done1), 0);
    loop1 = 1'b0;
    get_word(1, "t3_d1", w);
    @(negedge clk);
    check("t3_done", 32'(done1), 1);
    @(negedge clk);
    check("t3_done_drop", 32'(done1), 0);
    check("t3_idle", 32'(busy1), 0);

    // Abort while presenting addr 4.
    push_pass(0, 4);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 5; i++) get_word(0, "t4_word", w);
    check("t4_addr4", 32'(if0.rom_addr), 4);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("t4_valid", 32'(if0.out_valid), 0);
    check("t4_busy", 32'(busy0), 0);
    check("t4_addr", 32'(if0.rom_addr), 0);
    check("t4_done", 32'(done0), 0);
    @(negedge clk);
    check("t4_no_done", 32'(done0), 0);
    push_pass(0, 0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    get_word(0, "t4_fresh", w);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;

    // Asynchronous reset between edges during FETCH.
    push_pass(0, 0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    get_word(0, "t5_a", w);
    @(negedge clk);
    check("t5_pre_busy", 32'(busy0), 1);
    check("t5_pre_addr", 32'(if0.rom_addr), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy0), 0);
    check("t5_valid", 32'(if0.out_valid), 0);
    check("t5_done", 32'(done0), 0);
    check("t5_addr", 32'(if0.rom_addr), 0);
    check("t5_data", 32'(if0.out_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // start held high: ignored while busy and during FINISH, re-armed from IDLE.
    push_pass(0, 7);
    start0 = 1'b1;
    for (int i = 0; i < 8; i++) get_word(0, "t6_word", w);
    @(negedge clk);
    check("t6_done", 32'(done0), 1);
    @(negedge clk);
    check("t6_idle", 32'(busy0), 0);
    check("t6_idle_done", 32'(done0), 0);
    @(negedge clk);
    check("t6_refetch_busy", 32'(busy0), 1);
    check("t6_refetch_addr", 32'(if0.rom_addr), 0);
    push_pass(0, 0);
    get_word(0, "t6_again", w);
    start0 = 1'b0;
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
